// File: rtl/ext_irq_ctrl_if.sv
// rtl/ext_irq_ctrl_if.sv - interrupt lines, mask write and CPU handshake bundle for ext_irq_ctrl
interface ext_irq_ctrl_if;
    logic [3:0] irq_in;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       ExtIAck;
    logic       ERet;
    logic       ExtIRQ;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       busy;

    // CPU / system side
    modport master (
        output irq_in, mask_we, mask_wdata, ExtIAck, ERet,
        input  ExtIRQ, irq_id, pending, mask, busy
    );

    // Controller side
    modport slave (
        input  irq_in, mask_we, mask_wdata, ExtIAck, ERet,
        output ExtIRQ, irq_id, pending, mask, busy
    );
endinterface

// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - 4-source edge-triggered interrupt controller, optional input sync via IRQ_SYNC_EN
module ext_irq_ctrl (
    input  logic           clk,
    input  logic           reset,
    ext_irq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] irq_src;
    logic [3:0] irq_q;
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] pending_r;
    logic [3:0] mask_r;
    logic [3:0] active;
    logic       any_active;
    logic [1:0] first_id;
    logic       ext_irq_r;
    logic       busy_r;
    logic [1:0] irq_id_r;

`ifdef IRQ_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;

    // Two-flop synchronizer for asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 4'b0000;
            sync2 <= 4'b0000;
        end else begin
            sync1 <= bus.irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_src = sync2;
`else
    assign irq_src = bus.irq_in;
`endif

    assign rise       = irq_src & ~irq_q;
    assign active     = pending_r & mask_r;
    assign any_active = |active;
    assign clr        = (state == ST_REQ && bus.ExtIAck) ? (4'b0001 << irq_id_r) : 4'b0000;

    // Lowest set index wins; bit 0 has highest priority
    always_comb begin
        first_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active[i]) first_id = 2'(i);
        end
    end

    // Edge history: cleared on reset so a line high at release counts as one edge
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 4'b0000;
        else       irq_q <= irq_src;
    end

    // Pending bits: new edges win over the acknowledge clear
    always_ff @(posedge clk) begin
        if (reset) pending_r <= 4'b0000;
        else       pending_r <= (pending_r & ~clr) | rise;
    end

    // Mask register; arbitration this cycle still sees the old value
    always_ff @(posedge clk) begin
        if (reset)            mask_r <= 4'b1111;
        else if (bus.mask_we) mask_r <= bus.mask_wdata;
    end

    // Request/service handshake with registered ExtIRQ, busy and irq_id
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ext_irq_r <= 1'b0;
            busy_r    <= 1'b0;
            irq_id_r  <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_active) begin
                        irq_id_r  <= first_id;
                        ext_irq_r <= 1'b1;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.ExtIAck) begin
                        ext_irq_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= ST_SERV;
                    end
                end
                ST_SERV: begin
                    if (bus.ERet) begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    ext_irq_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ExtIRQ  = ext_irq_r;
    assign bus.busy    = busy_r;
    assign bus.irq_id  = irq_id_r;
    assign bus.pending = pending_r;
    assign bus.mask    = mask_r;

endmodule

// File: doc/ext_irq_ctrl.md
EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  in  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: irq_in  in  4  external interrupt lines; a rising edge marks a source pending.
REQ-005 Port: mask_we  in  1  mask write strobe.
REQ-006 Port: mask_wdata  in  4  new mask value; bit=1 enables that source.
REQ-007 Port: ExtIAck  in  1  acknowledge from the CPU controller.
REQ-008 Port: ERet  in  1  handler-return indication from the CPU controller.
REQ-009 Port: ExtIRQ  out  1  interrupt request to the CPU controller.
REQ-010 Port: irq_id  out  2  index of the source being requested or serviced.
REQ-011 Port: pending  out  4  registered pending bits.
REQ-012 Port: mask  out  4  registered mask.
REQ-013 Port: busy  out  1  high while a source is in service.

Function
REQ-014 Edge detect SHALL be rise = irq_in & ~irq_q, where irq_q is irq_in registered one cycle.
REQ-015 Next pending SHALL be (pending & ~clr) | rise; if set and clear hit the same bit in one cycle, set SHALL win.
REQ-016 mask SHALL load mask_wdata on the edge where mask_we=1; arbitration in that same cycle SHALL use the old mask.
REQ-017 The FSM SHALL have three states, encoded as 2 bits: IDLE, REQ, SERV.
REQ-018 IDLE: if (pending & mask) != 0, the FSM SHALL latch irq_id = lowest set index (bit 0 highest priority) and go to REQ; otherwise it SHALL stay in IDLE.
REQ-019 ExtIRQ SHALL be 1 exactly when state==REQ; it therefore rises one cycle after pending&mask becomes nonzero.
REQ-020 REQ: on ExtIAck=1, the FSM SHALL clear pending[irq_id] (clr one-hot) and go to SERV; otherwise it SHALL hold REQ with irq_id stable.
REQ-021 In REQ, ExtIRQ SHALL NOT be withdrawn by a mask write or by any other source.
REQ-022 SERV: busy=1 and irq_id held; on ERet=1 the FSM SHALL go to IDLE; new edges SHALL keep accumulating in pending.
REQ-023 ExtIAck in IDLE or SERV, and ERet in IDLE or REQ, SHALL be ignored.
REQ-024 Back-to-back: a source still pending after ERet SHALL re-raise ExtIRQ two cycles after the ERet edge (SERV->IDLE->REQ).
REQ-025 A line held high SHALL produce only one pending set; it SHALL re-arm only after it goes low.

Reset
REQ-026 reset SHALL force: state=IDLE, ExtIRQ=0, busy=0, irq_id=2'b00, pending=4'b0000, irq_q=4'b0000, mask=4'b1111 (plus synchronizer flops=0 when present).
REQ-027 reset SHALL take priority over every other input, including mid-REQ and mid-SERV; a line high at reset release SHALL register as one edge.

Configuration
REQ-028 Macro IRQ_SYNC_EN: when defined, irq_in SHALL pass through a 2-flop synchronizer before edge detect, adding 2 cycles of latency from irq_in to pending; when undefined, irq_in SHALL feed edge detect directly.

Verification (latencies stated with IRQ_SYNC_EN undefined)
REQ-029 irq_in=4'b0100 rising at cycle 0, mask=4'b1111 -> pending=4'b0100 at cycle 1, ExtIRQ=1 with irq_id=2 at cycle 2.
REQ-030 irq_in 4'b1010 rising together -> irq_id=1; ExtIAck at cycle 3 -> pending=4'b1000, busy=1; ERet at cycle 5 -> ExtIRQ=1 with irq_id=3 at cycle 7.
REQ-031 mask=4'b1110 and edge on bit 0 -> pending=4'b0001 with ExtIRQ staying 0; write mask=4'b1111 -> ExtIRQ rises 2 cycles after the write edge.
REQ-032 Edge on bit 2 in the same cycle that ExtIAck clears bit 2 -> pending[2] stays 1.
REQ-033 reset asserted while in SERV with pending=4'b0110 -> next cycle: ExtIRQ=0, busy=0, pending=0, mask=4'b1111.
REQ-034 With IRQ_SYNC_EN defined -> the REQ-029 stimulus gives pending at cycle 3 and ExtIRQ at cycle 4.
